dct_beffft_reod: RTL and testbench

DCT_BEFFFT_REOD -- requirements
Module: dct_befFFT_reod

---
 rtl/dct_beffft_reod.sv | 225 ++++++++++++++++++++++
 tb/tb_dct_beffft_reod.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_beffft_reod.sv
// DCT pre-FFT reorder buffer: even input samples land at n/2, odd samples count down from N-1,
// and each frame is read back in address order. Define DCT_REOD_PINGPONG_EN for a second bank.
module dct_beffft_reod #(
    parameter int wDataInOut = 16,
    parameter int wAddr      = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic [1:0]            sink_error,
    input  logic                  sink_sop,
    input  logic                  sink_eop,
    input  logic [wDataInOut-1:0] sink_real,
    input  logic [wDataInOut-1:0] sink_imag,
    input  logic [11:0]           fftpts_in,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic [1:0]            source_error,
    output logic                  source_sop,
    output logic                  source_eop,
    output logic [wDataInOut-1:0] source_real,
    output logic [wDataInOut-1:0] source_imag,
    output logic [11:0]           fftpts_out
);
`ifdef DCT_REOD_PINGPONG_EN
    localparam logic PP = 1'b1;
    localparam int   MA = wAddr + 1;
`else
    localparam logic PP = 1'b0;
    localparam int   MA = wAddr;
`endif
    localparam int          DW   = 2 * wDataInOut;
    localparam logic [12:0] MAXN = 13'(1) << wAddr;

    typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL} bank_st_e;
    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  err;
        logic [11:0] n;
    } side_t;
    typedef struct packed {
        logic [DW-1:0] data;
        side_t         side;
    } item_t;

    bank_st_e    bank_st_q [2];
    bank_st_e    bank_st_d [2];
    logic [11:0] bank_n_q [2];
    logic [11:0] bank_n_d [2];
    logic [1:0]  bank_err_q [2];
    logic [1:0]  bank_err_d [2];
    logic [1:0]  bank_rdd_q, bank_rdd_d;
    logic        wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, dr_sel_q, dr_sel_d;
    logic [11:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic        r_vld_q, r_vld_d, o_vld_q, o_vld_d, s_vld_q, s_vld_d;
    side_t       r_side_q, r_side_d;
    item_t       o_q, o_d, s_q, s_d, r_item;

    logic [DW-1:0]    mem_q [1<<MA];
    logic [DW-1:0]    rd_data_q;
    logic             we, re;
    logic [wAddr-1:0] wa, ra;
    logic [MA-1:0]    waddr, raddr;
    logic [11:0]      wnm1, rnm1;
    logic             n_legal, w_last, r_last, pop;
    logic [1:0]       occ;

`ifdef DCT_REOD_PINGPONG_EN
    assign waddr = {wr_sel_q, wa};
    assign raddr = {rd_sel_q, ra};
`else
    assign waddr = wa;
    assign raddr = ra;
`endif

    assign wnm1    = bank_n_q[wr_sel_q] - 12'd1;
    assign rnm1    = bank_n_q[rd_sel_q] - 12'd1;
    assign w_last  = (wr_cnt_q == wnm1);
    assign r_last  = (rd_cnt_q == rnm1);
    assign ra      = rd_cnt_q[wAddr-1:0];
    assign n_legal = (fftpts_in >= 12'd8) && ({1'b0, fftpts_in} <= MAXN) &&
                     ((fftpts_in & (fftpts_in - 12'd1)) == 12'd0);
    assign pop     = o_vld_q & source_ready;
    assign occ     = {1'b0, r_vld_q} + {1'b0, o_vld_q} + {1'b0, s_vld_q};
    assign r_item  = '{data: rd_data_q, side: r_side_q};

    // Held low through reset even though all banks read EMPTY then.
    assign sink_ready = rst_n && (bank_st_q[wr_sel_q] != B_FULL);

    assign source_valid               = o_vld_q;
    assign {source_real, source_imag} = o_q.data;
    assign source_sop                 = o_q.side.sop;
    assign source_eop                 = o_q.side.eop;
    assign source_error               = o_q.side.err;
    assign fftpts_out                 = o_q.side.n;

    always_comb begin
        bank_st_d  = bank_st_q;
        bank_n_d   = bank_n_q;
        bank_err_d = bank_err_q;
        bank_rdd_d = bank_rdd_q;
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        dr_sel_d   = dr_sel_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        r_vld_d    = 1'b0;
        r_side_d   = r_side_q;
        o_vld_d    = o_vld_q;
        o_d        = o_q;
        s_vld_d    = s_vld_q;
        s_d        = s_q;
        we         = 1'b0;
        re         = 1'b0;
        wa         = '0;

        if (pop && o_q.side.eop) begin
            bank_st_d[dr_sel_q]  = B_EMPTY;
            bank_rdd_d[dr_sel_q] = 1'b0;
            dr_sel_d             = dr_sel_q ^ PP;
        end

        // Issue only while output + skid can absorb everything in flight.
        if (bank_st_q[rd_sel_q] == B_FULL && !bank_rdd_q[rd_sel_q] &&
            occ <= (pop ? 2'd2 : 2'd1)) begin
            re       = 1'b1;
            r_vld_d  = 1'b1;
            r_side_d = '{sop: (rd_cnt_q == 12'd0), eop: r_last,
                         err: bank_err_q[rd_sel_q], n: bank_n_q[rd_sel_q]};
            if (r_last) begin
                rd_cnt_d             = '0;
                bank_rdd_d[rd_sel_q] = 1'b1;
                rd_sel_d             = rd_sel_q ^ PP;
            end else begin
                rd_cnt_d = rd_cnt_q + 12'd1;
            end
        end

        if (!o_vld_q || pop) begin
            if (s_vld_q) begin
                o_d     = s_q;
                o_vld_d = 1'b1;
                s_vld_d = r_vld_q;
                if (r_vld_q) s_d = r_item;
            end else begin
                o_vld_d = r_vld_q;
                if (r_vld_q) o_d = r_item;
            end
        end else if (r_vld_q) begin
            s_d     = r_item;
            s_vld_d = 1'b1;
        end

        if (sink_valid && sink_ready) begin
            if (sink_sop) begin
                if (n_legal) begin
                    bank_st_d[wr_sel_q]  = B_FILL;
                    bank_n_d[wr_sel_q]   = fftpts_in;
                    bank_err_d[wr_sel_q] = {|sink_error, sink_eop};
                    wr_cnt_d             = 12'd1;
                    we                   = 1'b1;
                end else begin
                    bank_st_d[wr_sel_q] = B_EMPTY;
                    wr_cnt_d            = '0;
                end
            end else if (bank_st_q[wr_sel_q] == B_FILL) begin
                we = 1'b1;
                wa = wr_cnt_q[0] ? (wnm1[wAddr-1:0] - wr_cnt_q[wAddr:1]) : wr_cnt_q[wAddr:1];
                bank_err_d[wr_sel_q] = bank_err_q[wr_sel_q] | {|sink_error, sink_eop ^ w_last};
                if (w_last) begin
                    bank_st_d[wr_sel_q] = B_FULL;
                    wr_cnt_d            = '0;
                    wr_sel_d            = wr_sel_q ^ PP;
                end else begin
                    wr_cnt_d = wr_cnt_q + 12'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= {sink_real, sink_imag};
        if (re) rd_data_q <= mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_st_q[b]  <= B_EMPTY;
                bank_n_q[b]   <= '0;
                bank_err_q[b] <= '0;
            end
            bank_rdd_q <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            dr_sel_q   <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            r_vld_q    <= 1'b0;
            r_side_q   <= '0;
            o_vld_q    <= 1'b0;
            o_q        <= '0;
            s_vld_q    <= 1'b0;
            s_q        <= '0;
        end else begin
            bank_st_q  <= bank_st_d;
            bank_n_q   <= bank_n_d;
            bank_err_q <= bank_err_d;
            bank_rdd_q <= bank_rdd_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            dr_sel_q   <= dr_sel_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            r_vld_q    <= r_vld_d;
            r_side_q   <= r_side_d;
            o_vld_q    <= o_vld_d;
            o_q        <= o_d;
            s_vld_q    <= s_vld_d;
            s_q        <= s_d;
        end
    end
endmodule

// File: tb/tb_dct_beffft_reod.sv
// Bench for dct_beffft_reod: expected output order is obtained by inverting the
// even-up / odd-down placement rule on each frame as it is sent.
module tb_dct_beffft_reod;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         sop;
        logic         eop;
        logic [1:0]   err;
        logic [11:0]  n;
    } item_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sink_valid, sink_ready, sink_sop, sink_eop;
    logic [1:0]   sink_error;
    logic [W-1:0] sink_real, sink_imag;
    logic [11:0]  fftpts_in;
    logic         source_valid, source_ready, source_sop, source_eop;
    logic [1:0]   source_error;
    logic [W-1:0] source_real, source_imag;
    logic [11:0]  fftpts_out;

    int    vectors = 0;
    int    miscmp = 0;
    int    stall_cyc = 0;
    int    rdy_mode = 0;
    item_t out_q[$];
    item_t exp_q[$];
    logic [48:0] cur_s, snap_s;
    bit    hold_chk = 1'b0;

    always #5 clk = ~clk;

    dct_beffft_reod dut (
        .clk(clk), .rst_n(rst_n),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
        .fftpts_in(fftpts_in),
        .source_valid(source_valid), .source_ready(source_ready), .source_error(source_error),
        .source_sop(source_sop), .source_eop(source_eop), .source_real(source_real),
        .source_imag(source_imag), .fftpts_out(fftpts_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        int ph;
        ph = 0;
        source_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin source_ready = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
                2: source_ready = 1'($urandom_range(0, 1));
                default: source_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        cur_s = {source_valid, source_sop, source_eop, source_error, source_real, source_imag, fftpts_out};
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) chk("hold_while_stalled", cur_s, snap_s);
            if (source_valid && source_ready)
                out_q.push_back('{re: source_real, im: source_imag, sop: source_sop,
                                  eop: source_eop, err: source_error, n: fftpts_out});
            hold_chk = source_valid && !source_ready;
            snap_s   = cur_s;
        end
    end

    task automatic beat(input logic sop, input logic eop, input logic [1:0] er,
                        input logic [W-1:0] re, input logic [W-1:0] im, input logic [11:0] pts);
        bit rdy;
        int t;
        sink_valid = 1'b1; sink_sop = sop; sink_eop = eop; sink_error = er;
        sink_real = re; sink_imag = im; fftpts_in = pts;
        t = 0;
        forever begin
            @(negedge clk);
            rdy = sink_ready;
            @(posedge clk);
            #1;
            if (rdy || t > 5000) break;
            stall_cyc++;
            t++;
        end
        if (!rdy) chk("sink_ready_timeout", rdy, 1);
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00;
    endtask

    task automatic send_frame(input int npts, input int nbeats, input int eop_idx,
                              input int err_idx, input logic [1:0] errv, input bit ramp);
        logic [W-1:0] xr[$];
        logic [W-1:0] xi[$];
        logic [1:0]   e;
        bit           legal;
        int           src;
        item_t        it;
        for (int n = 0; n < nbeats; n++) begin
            xr.push_back(ramp ? W'(n) : W'($urandom));
            xi.push_back(W'($urandom));
            beat(n == 0, n == eop_idx, (n == err_idx) ? errv : 2'b00, xr[n], xi[n], 12'(npts));
        end
        legal = 1'b0;
        for (int k = 3; k <= 11; k++) if (npts == (1 << k)) legal = 1'b1;
        if (legal && nbeats == npts) begin
            e = {(err_idx >= 0) && (err_idx < npts) && (errv != 2'b00), eop_idx != npts - 1};
            for (int k = 0; k < npts; k++) begin
                src = (k < npts / 2) ? 2 * k : 2 * (npts - 1 - k) + 1;
                it  = '{re: xr[src], im: xi[src], sop: (k == 0), eop: (k == npts - 1),
                        err: e, n: 12'(npts)};
                exp_q.push_back(it);
            end
        end
    endtask

    task automatic expect_out(input string tag);
        int t;
        t = 0;
        while (out_q.size() < exp_q.size() && t < 8000) begin
            @(posedge clk);
            t++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) chk(tag, out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, source_valid, 0);
        chk({tag, "_sop"}, source_sop, 0);
        chk({tag, "_eop"}, source_eop, 0);
        chk({tag, "_error"}, source_error, 0);
        chk({tag, "_real"}, source_real, 0);
        chk({tag, "_imag"}, source_imag, 0);
        chk({tag, "_fftpts"}, fftpts_out, 0);
        chk({tag, "_sink_ready"}, sink_ready, 0);
    endtask

    initial begin
        int lat;
        int np;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00;
        sink_real = '0; sink_imag = '0; fftpts_in = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("sink_ready_after_reset", sink_ready, 1);
        @(posedge clk); #1;

        // N=8 ramp, plus latency from the Nth transfer to the first valid
        rdy_mode = 0;
        send_frame(8, 8, 7, -1, 2'b00, 1'b1);
        lat = 0;
        @(negedge clk);
        while (!source_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("first_valid_latency", lat, 2);
        @(posedge clk); #1;
        expect_out("ramp8");

        rdy_mode = 1;
        send_frame(8, 8, 7, -1, 2'b00, 1'b1);
        expect_out("stall_1001_n8");
        send_frame(32, 32, 31, -1, 2'b00, 1'b0);
        expect_out("stall_1001_n32");

        rdy_mode = 2;
        for (int f = 0; f < 4; f++) begin
            np = 8 << $urandom_range(0, 3);
            send_frame(np, np, np - 1, -1, 2'b00, 1'b0);
        end
        expect_out("random_frames");

        rdy_mode = 0;
        send_frame(2048, 2048, 2047, -1, 2'b00, 1'b0);
        expect_out("max_n2048");

        stall_cyc = 0;
        send_frame(16, 16, 15, -1, 2'b00, 1'b0);
        send_frame(16, 16, 15, -1, 2'b00, 1'b0);
`ifdef DCT_REOD_PINGPONG_EN
        chk("pingpong_no_ready_drop", stall_cyc, 0);
`else
        chk("single_bank_ready_low_ge16", stall_cyc >= 16, 1);
`endif
        expect_out("back_to_back_n16");

        send_frame(8, 8, 4, -1, 2'b00, 1'b0);
        expect_out("early_eop");
        send_frame(8, 8, -1, -1, 2'b00, 1'b0);
        expect_out("missing_eop");
        send_frame(16, 16, 15, 5, 2'b10, 1'b0);
        expect_out("sink_error");
        send_frame(8, 8, 2, 3, 2'b01, 1'b0);
        expect_out("both_errors");

        // illegal N and stray non-sop beats: accepted, nothing comes out
        stall_cyc = 0;
        send_frame(12, 8, 7, -1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 2'b00, W'($urandom), W'($urandom), 12'd8);
        chk("illegal_n_ready_high", stall_cyc, 0);
        expect_out("illegal_n_dropped");
        send_frame(8, 8, 7, -1, 2'b00, 1'b0);
        expect_out("after_illegal_n");

        send_frame(8, 3, -1, -1, 2'b00, 1'b0);
        send_frame(8, 8, 7, -1, 2'b00, 1'b0);
        expect_out("sop_restart");

        send_frame(8, 4, -1, -1, 2'b00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        expect_out("no_output_after_reset");
        send_frame(8, 8, 7, -1, 2'b00, 1'b0);
        expect_out("frame_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end
endmodule
